// File: rtl/serial_pattern_detector_pkg.sv
// Shared defaults and width helper for the serial pattern detector slice.
// Latency: n/a (package); backpressure: n/a.
package serial_pattern_detector_pkg;

  localparam int              DEF_N       = 4;
  localparam logic [DEF_N-1:0] DEF_PATTERN = 4'b1011;
  localparam bit              DEF_OVERLAP = 1'b1;
  localparam int              DEF_CW      = 8;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Serial bit in, history/match/count status out for the pattern detector.
// Latency: n/a (wiring only); backpressure: none, every enabled bit is taken.
interface serial_pattern_detector_if
  import serial_pattern_detector_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
);

  logic          Enable;
  logic          Din;
  logic [N-1:0]  History;
  logic          Armed;
  logic          Match;
  logic [CW-1:0] MatchCount;
  logic          Saturated;

  modport master (
    output Enable, Din,
    input  History, Armed, Match, MatchCount, Saturated
  );

  modport slave (
    input  Enable, Din,
    output History, Armed, Match, MatchCount, Saturated
  );

endinterface

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating up-counter with registered all-ones flag, negedge clocked.
// Latency: 1 falling edge from inc to count; backpressure: none, holds at all ones.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          all_ones
);

  localparam logic [CW-1:0] LAST_STEP = ~CW'(1);

  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) begin
      count    <= '0;
      all_ones <= 1'b0;
    end else if (inc && !all_ones) begin
      count    <= count + CW'(1);
      all_ones <= (count == LAST_STEP);
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Shifts enabled serial bits into an N-bit history and flags PATTERN matches.
// Latency: Match on the falling edge sampling the last bit; backpressure: none.
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int             N       = DEF_N,
  parameter logic [N-1:0]   PATTERN = N'(DEF_PATTERN),
  parameter bit             OVERLAP = DEF_OVERLAP,
  parameter int             CW      = DEF_CW
) (
  input  logic                     Clock,
  input  logic                     Reset,
  serial_pattern_detector_if.slave bus
);

  localparam int             FW   = clog2(N + 1);
  localparam logic [FW-1:0]  FULL = FW'(N);

  logic [N-1:0]  hist;
  logic [FW-1:0] fill;
  logic          armed_q;
  logic          match_q;
  logic [N-1:0]  next_hist;
  logic [FW-1:0] next_fill;
  logic          hit;
  logic [CW-1:0] count;
  logic          saturated;

  always_comb begin
    next_hist = {hist[N-2:0], bus.Din};
    next_fill = (fill == FULL) ? fill : fill + FW'(1);
    hit       = bus.Enable && (next_fill == FULL) && (next_hist == PATTERN);
  end

  // Without overlap a hit restarts the fill count but leaves the history bits in place.
  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) begin
      hist    <= '0;
      fill    <= '0;
      armed_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (bus.Enable) begin
        hist <= next_hist;
        if (hit && (OVERLAP == 1'b0)) begin
          fill    <= '0;
          armed_q <= 1'b0;
        end else begin
          fill    <= next_fill;
          armed_q <= (next_fill == FULL);
        end
      end
    end
  end

  sat_counter #(.CW(CW)) u_match_cnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .inc      (hit),
    .count    (count),
    .all_ones (saturated)
  );

  assign bus.History    = hist;
  assign bus.Armed      = armed_q;
  assign bus.Match      = match_q;
  assign bus.MatchCount = count;
  assign bus.Saturated  = saturated;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Four detector configurations fed one shared stream; a scoreboard compares each against a reference model.
module tb_serial_pattern_detector;
  import serial_pattern_detector_pkg::*;

  localparam int NI = 4;

  typedef struct packed {
    logic [NI-1:0][3:0] hist;
    logic [NI-1:0][7:0] cnt;
    logic [NI-1:0]      armed;
    logic [NI-1:0]      match;
    logic [NI-1:0]      sat;
  } obs_t;

  logic Clock;
  logic Reset;
  logic enable;
  logic din;

  int pat_a  [NI] = '{11, 11, 0, 11};
  bit ovl_a  [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cmax_a [NI] = '{255, 255, 255, 15};

  int m_hist [NI];
  int m_seen [NI];
  int m_cnt  [NI];

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_pattern_detector_if #(.N(4), .CW(8)) bus0 ();
  serial_pattern_detector_if #(.N(4), .CW(8)) bus1 ();
  serial_pattern_detector_if #(.N(4), .CW(8)) bus2 ();
  serial_pattern_detector_if #(.N(4), .CW(4)) bus3 ();

  assign bus0.Enable = enable;
  assign bus0.Din    = din;
  assign bus1.Enable = enable;
  assign bus1.Din    = din;
  assign bus2.Enable = enable;
  assign bus2.Din    = din;
  assign bus3.Enable = enable;
  assign bus3.Din    = din;

  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(8)) dut0 (
    .Clock(Clock), .Reset(Reset), .bus(bus0.slave));
  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(8)) dut1 (
    .Clock(Clock), .Reset(Reset), .bus(bus1.slave));
  serial_pattern_detector #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CW(8)) dut2 (
    .Clock(Clock), .Reset(Reset), .bus(bus2.slave));
  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(4)) dut3 (
    .Clock(Clock), .Reset(Reset), .bus(bus3.slave));

  initial Clock = 1'b1;
  always #5 Clock = ~Clock;

  function automatic obs_t sample_dut();
    obs_t a;
    a.hist[0] = bus0.History;  a.cnt[0] = bus0.MatchCount;
    a.armed[0] = bus0.Armed;   a.match[0] = bus0.Match;  a.sat[0] = bus0.Saturated;
    a.hist[1] = bus1.History;  a.cnt[1] = bus1.MatchCount;
    a.armed[1] = bus1.Armed;   a.match[1] = bus1.Match;  a.sat[1] = bus1.Saturated;
    a.hist[2] = bus2.History;  a.cnt[2] = bus2.MatchCount;
    a.armed[2] = bus2.Armed;   a.match[2] = bus2.Match;  a.sat[2] = bus2.Saturated;
    a.hist[3] = bus3.History;  a.cnt[3] = {4'b0000, bus3.MatchCount};
    a.armed[3] = bus3.Armed;   a.match[3] = bus3.Match;  a.sat[3] = bus3.Saturated;
    return a;
  endfunction

  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h, want %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input obs_t a, input obs_t e);
    for (int i = 0; i < NI; i++) begin
      cmp({tag, "_history"}, i, 32'(a.hist[i]), 32'(e.hist[i]));
      cmp({tag, "_armed"},   i, 32'(a.armed[i]), 32'(e.armed[i]));
      cmp({tag, "_match"},   i, 32'(a.match[i]), 32'(e.match[i]));
      cmp({tag, "_count"},   i, 32'(a.cnt[i]), 32'(e.cnt[i]));
      cmp({tag, "_sat"},     i, 32'(a.sat[i]), 32'(e.sat[i]));
    end
  endtask

  // Reference: the history is the last four accepted bits as a number; a match
  // needs at least four bits seen since reset (or since the last hit when overlap is off).
  task automatic model_reset();
    obs_t e;
    for (int i = 0; i < NI; i++) begin
      m_hist[i] = 0;
      m_seen[i] = 0;
      m_cnt[i]  = 0;
    end
    e = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit en, input bit d);
    obs_t e;
    bit   hit;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      hit = 1'b0;
      if (en) begin
        m_hist[i] = (m_hist[i] * 2 + int'(d)) % 16;
        if (m_seen[i] < 4) m_seen[i]++;
        hit = (m_seen[i] == 4) && (m_hist[i] == pat_a[i]);
        if (hit) begin
          if (m_cnt[i] < cmax_a[i]) m_cnt[i]++;
          if (!ovl_a[i]) m_seen[i] = 0;
        end
      end
      e.hist[i]  = 4'(m_hist[i]);
      e.armed[i] = (m_seen[i] == 4);
      e.match[i] = hit;
      e.cnt[i]   = 8'(m_cnt[i]);
      e.sat[i]   = (m_cnt[i] == cmax_a[i]);
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input bit en, input bit d);
    @(posedge Clock);
    #1;
    Reset  = 1'b0;
    enable = en;
    din    = d;
    model_step(en, d);
  endtask

  // Reset is raised between falling edges; outputs must clear without waiting for one.
  task automatic pulse_reset();
    obs_t zero;
    zero = '0;
    @(posedge Clock);
    #1;
    enable = 1'($urandom_range(0, 1));
    din    = 1'($urandom_range(0, 1));
    Reset  = 1'b1;
    #1;
    cmp_all("async_reset", sample_dut(), zero);
    model_reset();
  endtask

  task automatic feed(input logic [31:0] bits, input int len);
    logic [31:0] b;
    b = bits;
    for (int k = len - 1; k >= 0; k--) step(1'b1, b[k]);
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp_all("cycle", sample_dut(), e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog @%0t: got timeout, want completion", $time);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin : stimulus
    Reset  = 1'b1;
    enable = 1'b0;
    din    = 1'b0;

    pulse_reset();
    feed(32'b10110110, 8);

    pulse_reset();
    feed(32'b0000, 4);

    pulse_reset();
    feed(32'b10, 2);
    repeat (3) step(1'b0, 1'b1);
    feed(32'b11, 2);

    pulse_reset();
    feed(32'b1011, 4);
    for (int r = 0; r < 19; r++) feed(32'b011, 3);

    pulse_reset();
    feed(32'b101, 3);
    pulse_reset();
    feed(32'b111011, 6);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge Clock);
    #1;
    cmp("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
